// File: rtl/vend_change_tx.sv
// rtl/vend_change_tx.sv - greedy coin-change transmitter emitting coin codes on D_out
// Outputs are registered, so each one shows the action of the state in the previous cycle.
module vend_change_tx #(
  parameter int AW         = 4,
  parameter int SW         = 4,
  parameter int INIT_1Y    = 4,
  parameter int INIT_05    = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Load,
  input  logic [AW-1:0] Amount,
  input  logic          Refill,
  output logic [1:0]    D_out,
  output logic          Busy,
  output logic          Done,
  output logic          Short,
  output logic [SW-1:0] Stock_1y,
  output logic [SW-1:0] Stock_05
);

  localparam int CW  = ((AW > SW) ? AW : SW) + 1;
  localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_05   = 2'b01;
  localparam logic [1:0] COIN_1Y   = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_EMIT, S_GAP, S_FIN} state_t;

  state_t        state_q;
  logic [AW-1:0] rem_q;
  logic [GCW-1:0] gap_q;
  logic          short_pend_q;
  logic [1:0]    d_out_q;
  logic          busy_q;
  logic          done_q;
  logic          short_q;
  logic [SW-1:0] stock_1y_q;
  logic [SW-1:0] stock_05_q;

  logic [CW-1:0] half_w;
  logic [CW-1:0] s1_w;
  logic [CW-1:0] n1_w;
  logic [CW-1:0] n05_w;
  logic          short_calc;
  logic          take_1y;
  logic [AW-1:0] rem_after;

  // Feasibility: after using as many 1-yuan coins as possible, the rest must fit in 0.5 stock.
  always_comb begin
    half_w     = CW'(rem_q >> 1);
    s1_w       = CW'(stock_1y_q);
    n1_w       = (s1_w < half_w) ? s1_w : half_w;
    n05_w      = CW'(rem_q) - (n1_w << 1);
    short_calc = n05_w > CW'(stock_05_q);
    take_1y    = (rem_q >= AW'(2)) && (stock_1y_q != '0);
    rem_after  = take_1y ? (rem_q - AW'(2)) : (rem_q - AW'(1));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      gap_q        <= '0;
      short_pend_q <= 1'b0;
      d_out_q      <= COIN_NONE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
      stock_1y_q   <= SW'(INIT_1Y);
      stock_05_q   <= SW'(INIT_05);
    end else begin
      d_out_q <= COIN_NONE;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      busy_q  <= 1'b1;
      case (state_q)
        S_IDLE: begin
          busy_q <= Load;
          if (Load) begin
            rem_q   <= Amount;
            state_q <= S_CHECK;
          end else if (Refill) begin
            stock_1y_q <= SW'(INIT_1Y);
            stock_05_q <= SW'(INIT_05);
          end
        end
        S_CHECK: begin
          short_pend_q <= (rem_q != '0) && short_calc;
          if (rem_q == '0 || short_calc) state_q <= S_FIN;
          else                           state_q <= S_EMIT;
        end
        S_EMIT: begin
          if (take_1y) begin
            d_out_q    <= COIN_1Y;
            stock_1y_q <= stock_1y_q - SW'(1);
          end else begin
            d_out_q    <= COIN_05;
            stock_05_q <= stock_05_q - SW'(1);
          end
          rem_q <= rem_after;
          if (rem_after == '0) begin
            state_q <= S_FIN;
          end else if (GAP_CYCLES > 0) begin
            gap_q   <= GCW'(GAP_CYCLES - 1);
            state_q <= S_GAP;
          end else begin
            state_q <= S_EMIT;
          end
        end
        S_GAP: begin
          if (gap_q == '0) state_q <= S_EMIT;
          else             gap_q   <= gap_q - GCW'(1);
        end
        S_FIN: begin
          done_q  <= 1'b1;
          short_q <= short_pend_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign D_out    = d_out_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Short    = short_q;
  assign Stock_1y = stock_1y_q;
  assign Stock_05 = stock_05_q;

endmodule

// File: tb/tb_vend_change_tx.sv
// tb/tb_vend_change_tx.sv - directed bench for vend_change_tx (gap=1 and gap=0 instances)
module tb_vend_change_tx;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;

  logic       load_a = 1'b0, refill_a = 1'b0;
  logic [3:0] amt_a = '0;
  logic [1:0] dout_a;
  logic       busy_a, done_a, short_a;
  logic [3:0] s1_a, s05_a;

  logic       load_b = 1'b0, refill_b = 1'b0;
  logic [3:0] amt_b = '0;
  logic [1:0] dout_b;
  logic       busy_b, done_b, short_b;
  logic [3:0] s1_b, s05_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  vend_change_tx #(.AW(4), .SW(4), .INIT_1Y(4), .INIT_05(4), .GAP_CYCLES(1)) dut_gap1 (
    .Clk(Clk), .Reset(Reset), .Load(load_a), .Amount(amt_a), .Refill(refill_a),
    .D_out(dout_a), .Busy(busy_a), .Done(done_a), .Short(short_a),
    .Stock_1y(s1_a), .Stock_05(s05_a)
  );

  vend_change_tx #(.AW(4), .SW(4), .INIT_1Y(4), .INIT_05(4), .GAP_CYCLES(0)) dut_gap0 (
    .Clk(Clk), .Reset(Reset), .Load(load_b), .Amount(amt_b), .Refill(refill_b),
    .D_out(dout_b), .Busy(busy_b), .Done(done_b), .Short(short_b),
    .Stock_1y(s1_b), .Stock_05(s05_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    Reset = 1'b1;

    check_eq("rst_dout", dout_a, 2'b00);
    check_eq("rst_busy", busy_a, 1'b0);
    check_eq("rst_done", done_a, 1'b0);
    check_eq("rst_short", short_a, 1'b0);
    check_eq("rst_s1", s1_a, 4);
    check_eq("rst_s05", s05_a, 4);

    // Amount=3 with gap 1; Refill and a second Load pulsed while busy are ignored.
    load_a = 1'b1; amt_a = 4'd3;
    tick();                                   // t0
    load_a = 1'b0;
    check_eq("a3_t0_busy", busy_a, 1'b1);
    check_eq("a3_t0_dout", dout_a, 2'b00);
    refill_a = 1'b1; load_a = 1'b1; amt_a = 4'd1;
    tick();                                   // t1
    refill_a = 1'b0; load_a = 1'b0;
    check_eq("a3_t1_dout", dout_a, 2'b00);
    tick();                                   // t2
    check_eq("a3_t2_dout", dout_a, 2'b10);
    check_eq("a3_t2_s1", s1_a, 3);
    tick();                                   // t3
    check_eq("a3_t3_dout", dout_a, 2'b00);
    check_eq("a3_t3_done", done_a, 1'b0);
    tick();                                   // t4
    check_eq("a3_t4_dout", dout_a, 2'b01);
    tick();                                   // t5
    check_eq("a3_t5_done", done_a, 1'b1);
    check_eq("a3_t5_short", short_a, 1'b0);
    check_eq("a3_t5_dout", dout_a, 2'b00);
    check_eq("a3_t5_busy", busy_a, 1'b1);
    check_eq("a3_s1", s1_a, 3);
    check_eq("a3_s05", s05_a, 3);
    tick();                                   // t6
    check_eq("a3_t6_busy", busy_a, 1'b0);
    check_eq("a3_t6_done", done_a, 1'b0);
    tick();
    check_eq("a3_idle_dout", dout_a, 2'b00);

    // Amount=0 with Refill together: Load wins, no coins, Done at t2.
    load_a = 1'b1; refill_a = 1'b1; amt_a = 4'd0;
    tick();
    load_a = 1'b0; refill_a = 1'b0;
    tick();
    check_eq("a0_t1_done", done_a, 1'b0);
    tick();
    check_eq("a0_t2_done", done_a, 1'b1);
    check_eq("a0_t2_short", short_a, 1'b0);
    check_eq("a0_t2_dout", dout_a, 2'b00);
    check_eq("a0_s1", s1_a, 3);
    check_eq("a0_s05", s05_a, 3);
    tick();
    check_eq("a0_busy_off", busy_a, 1'b0);

    refill_a = 1'b1;
    tick();
    refill_a = 1'b0;
    check_eq("refill_s1", s1_a, 4);
    check_eq("refill_s05", s05_a, 4);

    // Amount=8, no gap: four back-to-back 1-yuan coins, Done 6 cycles after Load.
    load_b = 1'b1; amt_b = 4'd8;
    tick();
    load_b = 1'b0;
    tick();
    check_eq("b8_t1_dout", dout_b, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("b8_coin%0d", i), dout_b, 2'b10);
      check_eq($sformatf("b8_done%0d", i), done_b, 1'b0);
    end
    tick();
    check_eq("b8_done", done_b, 1'b1);
    check_eq("b8_short", short_b, 1'b0);
    check_eq("b8_dout_fin", dout_b, 2'b00);
    check_eq("b8_s1", s1_b, 0);
    check_eq("b8_s05", s05_b, 4);
    tick();
    check_eq("b8_busy_off", busy_b, 1'b0);

    // Amount=5 with 0/4 stock: infeasible, Short with Done, no coins.
    load_b = 1'b1; amt_b = 4'd5;
    tick();
    load_b = 1'b0;
    tick();
    check_eq("b5_t1_dout", dout_b, 2'b00);
    check_eq("b5_t1_done", done_b, 1'b0);
    tick();
    check_eq("b5_done", done_b, 1'b1);
    check_eq("b5_short", short_b, 1'b1);
    check_eq("b5_dout", dout_b, 2'b00);
    check_eq("b5_s1", s1_b, 0);
    check_eq("b5_s05", s05_b, 4);
    tick();
    check_eq("b5_short_pulse", short_b, 1'b0);

    // Amount=7 with gap 1, asynchronous reset during the first gap.
    load_a = 1'b1; amt_a = 4'd7;
    tick();
    load_a = 1'b0;
    tick();
    tick();
    check_eq("a7_coin0", dout_a, 2'b10);
    check_eq("a7_s1_mid", s1_a, 3);
    #2;
    Reset = 1'b0;
    #1;
    check_eq("a7_rst_dout", dout_a, 2'b00);
    check_eq("a7_rst_busy", busy_a, 1'b0);
    check_eq("a7_rst_s1", s1_a, 4);
    check_eq("a7_rst_s05", s05_a, 4);
    check_eq("a7_rst_b_s1", s1_b, 4);
    #2;
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("a7_post_dout%0d", i), dout_a, 2'b00);
      check_eq($sformatf("a7_post_done%0d", i), done_a, 1'b0);
    end
    check_eq("a7_post_s1", s1_a, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
